// File: rtl/adc_proc_pkg.sv
// Shared definitions for the per-channel ADC post-processing stage:
// mode encodings and a width-parametrised signed saturation helper.
package adc_proc_pkg;

  typedef enum logic [1:0] {
    MODE_RAW  = 2'b00,
    MODE_MAN  = 2'b01,
    MODE_AUTO = 2'b10,
    MODE_RAMP = 2'b11
  } adc_mode_e;

  localparam int unsigned SAT_MAX_W = 32;

  // Clamp x into the signed range of a w-bit number (w <= SAT_MAX_W).
  function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
    input logic signed [SAT_MAX_W:0] x,
    input int unsigned                w
  );
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    hi = ((SAT_MAX_W+1)'(1) <<< (w - 1)) - (SAT_MAX_W+1)'(1);
    lo = -((SAT_MAX_W+1)'(1) <<< (w - 1));
    if (x > hi) return hi[SAT_MAX_W-1:0];
    if (x < lo) return lo[SAT_MAX_W-1:0];
    return x[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/adc_dc_est.sv
// Single-channel DC estimator: accumulates samples over a window and
// latches the floor-average when the shared window counter closes it.
module adc_dc_est #(
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     en_i,
  input  logic                     last_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [DATA_W-1:0] est_o
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  sum;
  logic signed [DATA_W-1:0] est_q;
  logic signed [DATA_W-1:0] est_d;

  // The accumulator is wide enough that a full window of extreme samples cannot wrap.
  always_comb begin
    sum   = acc_q + ACC_W'(sample_i);
    acc_d = acc_q;
    est_d = est_q;
    if (en_i) begin
      if (last_i) begin
        acc_d = '0;
        est_d = DATA_W'(sum >>> AVG_LOG2);
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_q <= '0;
      est_q <= '0;
    end else begin
      acc_q <= acc_d;
      est_q <= est_d;
    end
  end

  assign est_o = est_q;

endmodule

// File: rtl/adc_dcoff_chan_proc.sv
// Per-channel ADC post-processing: raw / manual offset / auto DC removal / ramp,
// two-stage pipeline with saturation, sticky overflow flags and estimate readback.
module adc_dcoff_chan_proc
  import adc_proc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 10,
  localparam int RD_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     adc_valid,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic [2*NUM_CH-1:0]      mif_adc_mode,
  input  logic [NUM_CH*DATA_W-1:0] mif_dcoff,
  input  logic                     mif_dcoff_freeze,
  input  logic                     mif_sat_clr,
  input  logic [RD_W-1:0]          mif_rd_ch,
  output logic [NUM_CH*DATA_W-1:0] adc_data_out,
  output logic                     adc_valid_out,
  output logic [DATA_W-1:0]        dcoff_rd_data,
  output logic                     dcoff_est_valid,
  output logic [NUM_CH-1:0]        sat_flag
);

  logic [AVG_LOG2-1:0]      win_cnt_q;
  logic                     est_en;
  logic                     win_last;
  logic                     est_valid_q;
  logic                     s1_valid_q;
  logic                     valid_out_q;
  logic [DATA_W-1:0]        rd_data_q;
  logic signed [DATA_W-1:0] est_w [NUM_CH];

  assign est_en   = adc_valid & ~mif_dcoff_freeze;
  assign win_last = &win_cnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      win_cnt_q   <= '0;
      est_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      valid_out_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      s1_valid_q  <= adc_valid;
      valid_out_q <= s1_valid_q;
      if (est_en) begin
        win_cnt_q <= win_cnt_q + AVG_LOG2'(1);
        if (win_last) est_valid_q <= 1'b1;
      end
      rd_data_q <= (int'(mif_rd_ch) < NUM_CH) ? est_w[mif_rd_ch] : '0;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] off;
    adc_mode_e                mode;
    logic [DATA_W-1:0]        ramp_q;
    logic [DATA_W-1:0]        s1_raw_q;
    logic [DATA_W-1:0]        s1_ramp_q;
    logic signed [DATA_W:0]   s1_diff_q;
    adc_mode_e                s1_mode_q;
    logic signed [DATA_W-1:0] sat_val;
    logic                     ovf;
    logic [DATA_W-1:0]        out_q;
    logic [DATA_W-1:0]        out_d;
    logic                     sat_q;
    logic                     sat_d;

    assign sample = adc_data[gi*DATA_W +: DATA_W];
    assign mode   = adc_mode_e'(mif_adc_mode[2*gi +: 2]);

    // Auto mode subtracts nothing until the first window has produced an estimate.
    always_comb begin
      off = '0;
      if (mode == MODE_MAN)                      off = mif_dcoff[gi*DATA_W +: DATA_W];
      else if (mode == MODE_AUTO && est_valid_q) off = est_w[gi];
    end

    adc_dc_est #(
      .DATA_W  (DATA_W),
      .AVG_LOG2(AVG_LOG2)
    ) u_est (
      .clk     (sys_clk),
      .srst    (sys_rst),
      .en_i    (est_en),
      .last_i  (win_last),
      .sample_i(sample),
      .est_o   (est_w[gi])
    );

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        ramp_q    <= '0;
        s1_raw_q  <= '0;
        s1_ramp_q <= '0;
        s1_diff_q <= '0;
        s1_mode_q <= MODE_RAW;
      end else if (adc_valid) begin
        ramp_q    <= ramp_q + DATA_W'(1);
        s1_raw_q  <= sample;
        s1_ramp_q <= ramp_q;
        s1_diff_q <= (DATA_W+1)'(sample) - (DATA_W+1)'(off);
        s1_mode_q <= mode;
      end
    end

    // A set from a new overflow overrides a coincident clear.
    always_comb begin
      sat_val = DATA_W'(sat_signed((SAT_MAX_W+1)'(s1_diff_q), DATA_W));
      ovf     = (s1_diff_q != (DATA_W+1)'(sat_val));
      out_d   = out_q;
      sat_d   = sat_q & ~mif_sat_clr;
      if (s1_valid_q) begin
        case (s1_mode_q)
          MODE_RAW:  out_d = s1_raw_q;
          MODE_MAN,
          MODE_AUTO: begin
            out_d = sat_val;
            if (ovf) sat_d = 1'b1;
          end
          MODE_RAMP: out_d = s1_ramp_q;
          default:   out_d = s1_raw_q;
        endcase
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        out_q <= '0;
        sat_q <= 1'b0;
      end else begin
        out_q <= out_d;
        sat_q <= sat_d;
      end
    end

    assign adc_data_out[gi*DATA_W +: DATA_W] = out_q;
    assign sat_flag[gi]                      = sat_q;
  end

  assign adc_valid_out   = valid_out_q;
  assign dcoff_est_valid = est_valid_q;
  assign dcoff_rd_data   = rd_data_q;

endmodule

// File: doc/adc_dcoff_chan_proc.md
# adc_dcoff_chan_proc

Parametrised per-channel ADC post-processing stage on `sys_clk`, between the ADC receive block and downstream baseband consumers. It is the successor to the fixed four-channel raw/DC-offset output selector, and each channel gets its own mode:

- raw passthrough;
- manual offset subtraction;
- automatic DC estimation over a power-of-two window, then subtraction;
- test ramp.

All arithmetic paths saturate. Per-channel sticky overflow flags and an estimate readback port serve the management interface (mif).

## Interface
Parameters:
- `NUM_CH`, 4, number of ADC channels (1..8).
- `DATA_W`, 16, signed sample width.
- `AVG_LOG2`, 10, DC-estimate window is 2^AVG_LOG2 valid samples (1..16).

Ports:
- `sys_clk`  in  1  processing clock; all logic on rising edge.
- `sys_rst`  in  1  reset; synchronous, active-high.
- `adc_valid`  in  1  qualifies `adc_data` (all channels share one strobe).
- `adc_data`  in  NUM_CH*DATA_W  signed samples; channel k occupies bits [k*DATA_W +: DATA_W].
- `mif_adc_mode`  in  2*NUM_CH  per-channel mode, channel k at [2k +: 2]: 00 raw, 01 manual, 10 auto, 11 ramp.
- `mif_dcoff`  in  NUM_CH*DATA_W  signed manual offsets, packed like `adc_data`.
- `mif_dcoff_freeze`  in  1  holds all estimators: window counter, accumulators and estimates.
- `mif_sat_clr`  in  1  single-cycle clear of sticky saturation flags.
- `mif_rd_ch`  in  $clog2(NUM_CH) (min 1)  channel selected for estimate readback.
- `adc_data_out`  out  NUM_CH*DATA_W  processed samples.
- `adc_valid_out`  out  1  qualifies `adc_data_out`.
- `dcoff_rd_data`  out  DATA_W  estimate of channel `mif_rd_ch`, registered.
- `dcoff_est_valid`  out  1  high once the first window has completed.
- `sat_flag`  out  NUM_CH  sticky saturation flags, one per channel.

## Operation
- **Mode and offset sampling:** `mif_adc_mode` and `mif_dcoff` are sampled on each valid sample. There is no shadowing, so a mode change takes effect on the next valid sample.
- **Estimator, shared window counter:**
  - `win_cnt` is AVG_LOG2 bits wide and increments on each `adc_valid` unless frozen.
  - Per-channel accumulator `acc[k]` is signed, DATA_W+AVG_LOG2 bits, and adds each valid sample.
- **Window completion:** on the valid sample where `win_cnt` is all ones:
  - `est[k] <= (acc[k] + sample) >>> AVG_LOG2` (arithmetic shift, floor);
  - `acc[k] <= 0` and `win_cnt` wraps to 0;
  - `dcoff_est_valid <= 1`.
- **Estimates run in every mode**, so switching to auto is immediately usable.
- **Freeze:** while `mif_dcoff_freeze` is high, `win_cnt`, `acc` and `est` hold and samples are not accumulated. Data output continues normally.
- **Offset used in auto mode before `dcoff_est_valid`:** zero.
- **Subtraction:**
  - Computed at DATA_W+1 bits signed: `diff = sample - off`.
  - `off` is `mif_dcoff[k]` in manual mode and `est[k]` in auto mode.
  - Saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- **Saturation flag:** when saturation engages on a valid sample, `sat_flag[k]` sets. If `mif_sat_clr` arrives in the same cycle as a new saturation, set wins.
- **Raw mode:** sample passes unchanged and cannot saturate.
- **Ramp mode:** output is a per-channel DATA_W counter, starting at 0 at reset and incremented per valid sample. It wraps 2^DATA_W-1 → 0 and runs in all modes.
- **Invalid cycles:** when `adc_valid` is low, no state advances and outputs hold.

## Timing
- Latency is 2 `sys_clk` cycles:
  - stage 1 registers the input and computes the DATA_W+1 difference;
  - stage 2 saturates, applies the mode mux and registers the output.
- `adc_valid_out` is `adc_valid` delayed by 2 cycles. Back-to-back valids give full throughput.
- `est[k]` updates one cycle after the window-closing sample. Auto-mode output uses the new estimate from the next valid sample onward.
- `dcoff_rd_data` follows `mif_rd_ch` with 1 cycle latency.
- **Reset values** (synchronous; a reset mid-window discards the partial accumulation):
  - `adc_data_out` = 0, `adc_valid_out` = 0, `dcoff_rd_data` = 0;
  - `dcoff_est_valid` = 0, `sat_flag` = 0;
  - `win_cnt`, `acc`, `est`, ramp counters and pipeline registers all = 0.

## Structure
- Shared package `adc_proc_pkg` holds:
  - mode encodings (`MODE_RAW`, `MODE_MAN`, `MODE_AUTO`, `MODE_RAMP`);
  - the saturation helper function, parametrised by width.
- One sub-module, `adc_dc_est`, is the single-channel accumulator plus estimate register. It is instantiated NUM_CH times by generate.
- The window counter is shared and lives in the top level.

## Test plan
Bench uses NUM_CH=4, DATA_W=16, AVG_LOG2=4.
1. **Raw mode:** all modes 00, continuous valid ramp of inputs → outputs equal inputs 2 cycles later; `sat_flag` = 0.
2. **Auto mode:** mode 10 on ch0, 16 valid samples of constant 1000 → `dcoff_est_valid` rises; estimate 1000 on `dcoff_rd_data` (rd_ch=0); subsequent outputs 0.
3. **Manual saturation:** mode 01 on ch1, `mif_dcoff` = -200, input 32700 → output 32767 and `sat_flag[1]` = 1. Pulsing `mif_sat_clr` with no further saturation → 0. Clear coincident with a new saturation → stays 1.
4. **Floor rounding:** estimate window of alternating -3/-4 → estimate -4 (floor of -3.5).
5. **Freeze and reset:** `mif_dcoff_freeze` high for 20 valids mid-window → estimate unchanged, window resumes at frozen count. `sys_rst` asserted mid-window → all outputs 0 next cycle; next estimate needs a full 16 samples.
6. **Ramp and gaps:** mode 11 with `adc_valid` toggling 1/0 → output 0,1,2… on valid cycles only; wraps 65535 → 0.
